// File: rtl/pim_tile_engine_if.sv
// Chunk interface between the partitioning controller (master) and a PIM tile engine (slave).
// Tiles are flat row-major vectors; element n occupies bits [n*WIDTH +: WIDTH].
interface pim_tile_engine_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CHUNK_SIZE = 8
);
    localparam int unsigned TileW = WIDTH * CHUNK_SIZE * CHUNK_SIZE;

    logic             valid;
    logic [TileW-1:0] matrixA;
    logic [TileW-1:0] matrixB;
    logic [TileW-1:0] result;
    logic             result_valid;
    logic             busy;

    modport master (
        output valid, matrixA, matrixB,
        input  result, result_valid, busy
    );

    modport slave (
        input  valid, matrixA, matrixB,
        output result, result_valid, busy
    );
endinterface

// File: rtl/pim_tile_engine.sv
// Sequential single-MAC N x N tile multiplier with fixed N**3-cycle latency.
// Optional macro PIM_TILE_SATURATE_EN: signed operands, wide accumulator, clamped results.
module pim_tile_engine #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CHUNK_SIZE = 8,
    parameter int unsigned ID         = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    pim_tile_engine_if.slave       bus
);
    localparam int unsigned N     = CHUNK_SIZE;
    localparam int unsigned Elems = N * N;
    localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ElemW = (Elems > 1) ? $clog2(Elems) : 1;
    localparam logic [IdxW-1:0]  LastIdx = IdxW'(N - 1);
    localparam logic [ElemW-1:0] RowLen  = ElemW'(N);
`ifdef PIM_TILE_SATURATE_EN
    localparam int unsigned AccW = 2 * WIDTH + IdxW;
    localparam logic [AccW-1:0] SatMax = {{(AccW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [AccW-1:0] SatMin = {{(AccW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`else
    localparam int unsigned AccW = WIDTH;
`endif

    typedef enum logic [0:0] {StIdle, StCompute} state_e;

    state_e                        state_q;
    logic [Elems-1:0][WIDTH-1:0]   a_q, b_q, stage_q, result_q, stage_d;
    logic [IdxW-1:0]               i_q, j_q, k_q;
    logic [AccW-1:0]               acc_q, sum;
    logic [ElemW-1:0]              a_idx, b_idx, c_idx;
    logic [WIDTH-1:0]              a_elem, b_elem, elem_val;
    logic                          busy_q, result_valid_q;

    // ID only distinguishes instances; it has no functional effect.
    logic unused_id;
    assign unused_id = ^ID;

`ifdef PIM_TILE_SATURATE_EN
    logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
`else
    logic [WIDTH-1:0] prod;
`endif

    always_comb begin
        a_idx  = ElemW'(i_q) * RowLen + ElemW'(k_q);
        b_idx  = ElemW'(k_q) * RowLen + ElemW'(j_q);
        c_idx  = ElemW'(i_q) * RowLen + ElemW'(j_q);
        a_elem = a_q[a_idx];
        b_elem = b_q[b_idx];
`ifdef PIM_TILE_SATURATE_EN
        a_ext = {{WIDTH{a_elem[WIDTH-1]}}, a_elem};
        b_ext = {{WIDTH{b_elem[WIDTH-1]}}, b_elem};
        prod  = a_ext * b_ext;
        sum   = acc_q + {{IdxW{prod[2*WIDTH-1]}}, prod};
        if ($signed(sum) > $signed(SatMax)) begin
            elem_val = {1'b0, {(WIDTH-1){1'b1}}};
        end else if ($signed(sum) < $signed(SatMin)) begin
            elem_val = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            elem_val = sum[WIDTH-1:0];
        end
`else
        prod     = a_elem * b_elem;
        sum      = acc_q + prod;
        elem_val = sum;
`endif
        stage_d        = stage_q;
        stage_d[c_idx] = elem_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            a_q            <= '0;
            b_q            <= '0;
            stage_q        <= '0;
            result_q       <= '0;
            i_q            <= '0;
            j_q            <= '0;
            k_q            <= '0;
            acc_q          <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.valid) begin
                        a_q     <= bus.matrixA;
                        b_q     <= bus.matrixB;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCompute;
                    end
                end
                StCompute: begin
                    if (k_q != LastIdx) begin
                        acc_q <= sum;
                        k_q   <= k_q + 1'b1;
                    end else begin
                        stage_q <= stage_d;
                        acc_q   <= '0;
                        k_q     <= '0;
                        if (j_q != LastIdx) begin
                            j_q <= j_q + 1'b1;
                        end else begin
                            j_q <= '0;
                            if (i_q != LastIdx) begin
                                i_q <= i_q + 1'b1;
                            end else begin
                                // Last element: publish staging tile including this sum.
                                i_q            <= '0;
                                result_q       <= stage_d;
                                result_valid_q <= 1'b1;
                                busy_q         <= 1'b0;
                                state_q        <= StIdle;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_pim_tile_engine.sv
// Directed bench for pim_tile_engine: latency, data, busy handling, reset abort, overflow.
// Expected overflow values follow PIM_TILE_SATURATE_EN when it is defined.
module tb_pim_tile_engine;
    localparam int W     = 32;
    localparam int N     = 8;
    localparam int E     = N * N;
    localparam int TileW = W * E;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pim_tile_engine_if #(.WIDTH(W), .CHUNK_SIZE(N)) bus ();

    pim_tile_engine #(.WIDTH(W), .CHUNK_SIZE(N), .ID(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [TileW-1:0] fill(input logic [W-1:0] v);
        logic [TileW-1:0] t;
        for (int n = 0; n < E; n++) t[n*W +: W] = v;
        return t;
    endfunction

    // Called on a falling edge; the following rising edge samples valid.
    task automatic start_op(input logic [TileW-1:0] a, input logic [TileW-1:0] b);
        bus.matrixA = a;
        bus.matrixB = b;
        bus.valid   = 1'b1;
        @(negedge clk);
        bus.valid   = 1'b0;
    endtask

    // Cycles counted from the accept edge until result_valid is seen, bounded.
    task automatic wait_done(output int cyc, output int bcyc);
        cyc  = 0;
        bcyc = 0;
        while (bus.result_valid !== 1'b1 && cyc < 600) begin
            if (bus.busy === 1'b1) bcyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.valid   = 1'b0;
        bus.matrixA = '0;
        bus.matrixB = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.result !== '0) begin
            errors++;
            $display("FAIL reset_result: got %h (elem 0) want 0", bus.result[W-1:0]);
        end
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_result_valid: got %b want 0", bus.result_valid);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        logic [TileW-1:0] a, b;
        int cyc, bcyc;
        for (int n = 0; n < E; n++) begin
            a[n*W +: W] = ((n / N) == (n % N)) ? 32'd1 : 32'd0;
            b[n*W +: W] = 32'(n + 1);
        end
        start_op(a, b);
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 512) begin
            errors++;
            $display("FAIL identity_latency: got %0d want 512", cyc);
        end
        checks++;
        if (bcyc != 512) begin
            errors++;
            $display("FAIL identity_busy_cycles: got %0d want 512", bcyc);
        end
        for (int n = 0; n < E; n++) begin
            checks++;
            if (bus.result[n*W +: W] !== 32'(n + 1)) begin
                errors++;
                $display("FAIL identity_elem %0d: got %h want %h", n, bus.result[n*W +: W], n + 1);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL identity_pulse_width: got rv=%b busy=%b want 0 0",
                     bus.result_valid, bus.busy);
        end
    endtask

    task automatic test_constant();
        int cyc, bcyc;
        start_op(fill(32'd2), fill(32'd3));
        bus.matrixA = fill(32'd9);
        bus.matrixB = fill(32'd7);
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 512) begin
            errors++;
            $display("FAIL constant_latency: got %0d want 512", cyc);
        end
        for (int n = 0; n < E; n++) begin
            checks++;
            if (bus.result[n*W +: W] !== 32'd48) begin
                errors++;
                $display("FAIL constant_elem %0d: got %h want 00000030", n, bus.result[n*W +: W]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        start_op(fill(32'd1), fill(32'd5));
        cyc = 0;
        while (bus.result_valid !== 1'b1 && cyc < 600) begin
            if (cyc == 10 || cyc == 300) begin
                bus.valid   = 1'b1;
                bus.matrixA = fill(32'd7);
            end else begin
                bus.valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.valid = 1'b0;
        checks++;
        if (cyc != 512) begin
            errors++;
            $display("FAIL busy_ignore_latency: got %0d want 512", cyc);
        end
        for (int n = 0; n < E; n++) begin
            checks++;
            if (bus.result[n*W +: W] !== 32'd40) begin
                errors++;
                $display("FAIL busy_ignore_elem %0d: got %h want 00000028", n, bus.result[n*W +: W]);
            end
        end
        // Start the next operation in the result_valid cycle itself.
        start_op(fill(32'd2), fill(32'd3));
        checks++;
        if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b rv=%b want 1 0", bus.busy, bus.result_valid);
        end
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 512) begin
            errors++;
            $display("FAIL b2b_latency: got %0d want 512", cyc);
        end
        for (int n = 0; n < E; n++) begin
            checks++;
            if (bus.result[n*W +: W] !== 32'd48) begin
                errors++;
                $display("FAIL b2b_elem %0d: got %h want 00000030", n, bus.result[n*W +: W]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int cyc, bcyc, pulses;
        start_op(fill(32'd1), fill(32'd1));
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < E; n++) begin
            checks++;
            if (bus.result[n*W +: W] !== 32'd0) begin
                errors++;
                $display("FAIL abort_result_elem %0d: got %h want 0", n, bus.result[n*W +: W]);
            end
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: got busy=%b rv=%b want 0 0", bus.busy, bus.result_valid);
        end
        // valid together with rst: reset wins.
        bus.valid = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        rst       = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins_busy: got %b want 0", bus.busy);
        end
        pulses = 0;
        repeat (600) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_pulse: got %0d pulses want 0", pulses);
        end
        start_op(fill(32'd1), fill(32'd1));
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 512) begin
            errors++;
            $display("FAIL restart_latency: got %0d want 512", cyc);
        end
        for (int n = 0; n < E; n++) begin
            checks++;
            if (bus.result[n*W +: W] !== 32'd8) begin
                errors++;
                $display("FAIL restart_elem %0d: got %h want 00000008", n, bus.result[n*W +: W]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int cyc, bcyc;
        logic [W-1:0] exp;
`ifdef PIM_TILE_SATURATE_EN
        exp = 32'h7FFF_FFFF;
`else
        exp = 32'h0000_0000;
`endif
        start_op(fill(32'h0001_0000), fill(32'h0001_0000));
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 512) begin
            errors++;
            $display("FAIL overflow_latency: got %0d want 512", cyc);
        end
        for (int n = 0; n < E; n++) begin
            checks++;
            if (bus.result[n*W +: W] !== exp) begin
                errors++;
                $display("FAIL overflow_elem %0d: got %h want %h", n, bus.result[n*W +: W], exp);
            end
        end
        @(negedge clk);
`ifdef PIM_TILE_SATURATE_EN
        start_op(fill(32'hFFFF_0000), fill(32'h0001_0000));
        wait_done(cyc, bcyc);
        for (int n = 0; n < E; n++) begin
            checks++;
            if (bus.result[n*W +: W] !== 32'h8000_0000) begin
                errors++;
                $display("FAIL underflow_elem %0d: got %h want 80000000", n, bus.result[n*W +: W]);
            end
        end
        @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_identity();
        test_constant();
        test_back_to_back();
        test_reset_mid_op();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
